qspi_flash_responder: RTL and testbench
=======================================

// Module: qspi_flash_responder
// PURPOSE
//  QSPI target (responder) emulating a small NOR-flash device, for on-chip loopback
//  and bench use against the QSPI master peripheral.
//  - Oversamples sclk_i/cs_ni/io_i on clk_i; SPI mode 0; MSB first.
//  - Decodes an 8-bit opcode sent on io[0], then serves reads and writes in x1/x2/x4
//    from an internal byte RAM.
//  - A backdoor port lets firmware and benches preload or inspect the RAM.
// PARAMETERS
//  DEPTH    256  RAM size in bytes, power of 2, 16..4096; address uses low log2(DEPTH) bits
//  DUMMY_N  8    dummy SCLK cycles for DOR/QOR
// PORTS
//  clk_i      in   1   system clock; must be >= 8x SCLK frequency
//  rst_i      in   1   reset, asynchronous, active-high
//  sclk_i     in   1   QSPI clock from master (asynchronous to clk_i)
//  cs_ni      in   1   chip select, active-low
//  io_i       in   4   sampled IO lines
//  io_o       out  4   driven IO values
//  io_oe_o    out  4   per-line output enable (1 = drive)
//  bd_addr_i  in   log2(DEPTH)  backdoor byte address
//  bd_wdata_i in   8   backdoor write data
//  bd_we_i    in   1   backdoor write strobe (1 clk_i)
//  bd_rdata_o out  8   backdoor read data, registered, 1 clk_i latency
// BEHAVIOUR
//  Sync/edge detect
//  - sclk_i, cs_ni and io_i each pass through 2 flip-flops.
//  - Rising/falling SCLK events are detected on the 3rd clk_i after the pin edge.
//  - Inputs are sampled on SCLK rise; io_o/io_oe_o are updated on SCLK fall.
//  - SCLK edges while CS is high are ignored.
//  Reset
//  - io_o=0, io_oe_o=0, bd_rdata_o=0, state=IDLE, WEL=0.
//  - RAM contents are not reset.
//  CS deassert (sync cs high)
//  - Any state returns to IDLE in 1 clk_i; io_oe_o=0 in the same cycle.
//  - Partial bytes are discarded.
//  - WEL is cleared if a PP/QPP was active.
//  FSM
//  - IDLE -> CMD on CS fall; CMD shifts 8 bits from io_i[0].
//  - 8th bit dispatch:
//    - 03 READ, 02 PP, 32 QPP -> ADDR
//    - 3B DOR, 6B QOR -> ADDR then DUMMY
//    - 05 RDSR1 -> STAT
//    - 06 WREN sets WEL, 04 WRDI clears WEL, both -> IGNORE
//    - any other opcode -> IGNORE
//  - ADDR: 24 bits on io_i[0]; the low log2(DEPTH) bits form the pointer, upper bits are ignored.
//  - DUMMY: DUMMY_N SCLK cycles, outputs tri-stated.
//  - RDATA: see Read data.
//  - WDATA: see Write data.
//  - STAT: drives {6'b0, WEL, WIP=0} on io_o[1] continuously, repeating while CS is low.
//  - IGNORE: outputs off until CS high.
//  Read data
//  - First data bit is driven on the SCLK fall that ends the last ADDR/DUMMY bit.
//  - x1: io_o[1] driven, io_oe_o=4'b0010.
//  - x2: io_oe_o=4'b0011; io_o[1:0] = {b7,b6},{b5,b4},{b3,b2},{b1,b0}.
//  - x4: io_oe_o=4'b1111; io_o[3:0] = b7..b4 then b3..b0.
//  - After each byte the pointer increments, wrapping DEPTH-1 -> 0; reads are unbounded.
//  Write data (PP x1 on io_i[0]; QPP x4 on io_i[3:0], high nibble first)
//  - If WEL=0 on entry: state -> IGNORE and no RAM write occurs.
//  - Each complete byte writes RAM[ptr] on the clk_i after its last sampled bit; the pointer then increments with wrap.
//  Backdoor vs QSPI
//  - Backdoor read/write is always available.
//  - A same-cycle write to the same address: the QSPI write wins.
//  - A QSPI read fetches the next byte at the byte boundary, so a backdoor write takes effect from the next unsent byte.
// TESTING
//  - Backdoor writes RAM[0x10..0x13]=A5,3C,0F,F0; READ 03 addr 000010, 32 SCLKs
//    -> io[1] bytes A5 3C 0F F0, io_oe_o=0010.
//  - QOR 6B addr 0000FE, 8 dummy cycles, DEPTH=256 -> nibbles of RAM[FE],RAM[FF],RAM[00];
//    io_oe_o=0000 during dummy cycles, 1111 in the data phase.
//  - PP 02 without WREN writing 55 -> RAM unchanged.
//    Then WREN 06; RDSR1 -> 02; PP 02 addr 20 data 11,22 -> RAM[20]=11, RAM[21]=22;
//    after CS high, RDSR1 -> 00.
//  - QPP 32 at addr 40, 3.5 bytes sent then CS high -> 3 bytes written, RAM[43] unchanged, state IDLE.
//  - rst_i asserted mid-READ -> io_oe_o=0 within the same cycle; after release, a new CS frame decodes correctly.
//  - Unknown opcode AB -> io_oe_o stays 0 for the whole frame; the next frame (READ) works.

Source files
------------

// File: rtl/qspi_flash_responder_if.sv
// rtl/qspi_flash_responder_if.sv - QSPI pin bundle between a bus master and the flash responder
interface qspi_flash_responder_if;
   logic       sclk_i;
   logic       cs_ni;
   logic [3:0] io_i;
   logic [3:0] io_o;
   logic [3:0] io_oe_o;

   modport master (output sclk_i, output cs_ni, output io_i, input io_o, input io_oe_o);
   modport slave  (input sclk_i, input cs_ni, input io_i, output io_o, output io_oe_o);
endinterface

// File: rtl/qspi_flash_responder.sv
// rtl/qspi_flash_responder.sv - oversampled QSPI NOR-flash responder with byte RAM and backdoor port
module qspi_flash_responder #(
   parameter int DEPTH   = 256,
   parameter int DUMMY_N = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   qspi_flash_responder_if.slave    qspi,
   input  logic [$clog2(DEPTH)-1:0] bd_addr_i,
   input  logic [7:0]               bd_wdata_i,
   input  logic                     bd_we_i,
   output logic [7:0]               bd_rdata_o
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_STAT, S_IGNORE
   } state_t;

   typedef enum logic [1:0] {L_X1, L_X2, L_X4} lane_t;

   state_t        state_q;
   lane_t         lane_q;
   logic          sclk_s1_q, sclk_s2_q, sclk_s3_q;
   logic          cs_s1_q, cs_s2_q;
   logic [3:0]    io_s1_q, io_s2_q;
   logic [7:0]    cnt_q;
   logic [7:0]    sh_q;
   logic [7:0]    tx_q;
   logic [AW-1:0] ptr_q;
   logic [AW-1:0] wr_addr_q;
   logic [7:0]    wr_data_q;
   logic          wr_en_q;
   logic          wel_q;
   logic          is_wr_q;
   logic          dummy_q;
   logic [3:0]    io_o_q, io_oe_q;
   logic [7:0]    bd_rdata_q;
   logic [7:0]    mem [DEPTH];

   logic          sclk_rise, sclk_fall;
   logic [7:0]    cmd_d, wsh_d, out_byte_d, tx_d, last_beat;
   logic [3:0]    io_d, oe_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sclk_s1_q <= 1'b0;
         sclk_s2_q <= 1'b0;
         sclk_s3_q <= 1'b0;
         cs_s1_q   <= 1'b1;
         cs_s2_q   <= 1'b1;
         io_s1_q   <= '0;
         io_s2_q   <= '0;
      end else begin
         sclk_s1_q <= qspi.sclk_i;
         sclk_s2_q <= sclk_s1_q;
         sclk_s3_q <= sclk_s2_q;
         cs_s1_q   <= qspi.cs_ni;
         cs_s2_q   <= cs_s1_q;
         io_s1_q   <= qspi.io_i;
         io_s2_q   <= io_s1_q;
      end
   end

   assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
   assign sclk_fall = ~sclk_s2_q & sclk_s3_q;

   // Output byte is fetched only at a byte boundary so backdoor writes land on the next unsent byte.
   always_comb begin
      cmd_d = {sh_q[6:0], io_s2_q[0]};
      wsh_d = (lane_q == L_X4) ? {sh_q[3:0], io_s2_q} : cmd_d;
      if (cnt_q == 8'd0) begin
         out_byte_d = (state_q == S_STAT) ? {6'b0, wel_q, 1'b0} : mem[ptr_q];
      end else begin
         out_byte_d = tx_q;
      end
      case (lane_q)
         L_X2: begin
            io_d      = {2'b00, out_byte_d[7:6]};
            oe_d      = 4'b0011;
            tx_d      = {out_byte_d[5:0], 2'b00};
            last_beat = 8'd3;
         end
         L_X4: begin
            io_d      = out_byte_d[7:4];
            oe_d      = 4'b1111;
            tx_d      = {out_byte_d[3:0], 4'b0000};
            last_beat = 8'd1;
         end
         default: begin
            io_d      = {2'b00, out_byte_d[7], 1'b0};
            oe_d      = 4'b0010;
            tx_d      = {out_byte_d[6:0], 1'b0};
            last_beat = 8'd7;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         lane_q    <= L_X1;
         cnt_q     <= '0;
         sh_q      <= '0;
         tx_q      <= '0;
         ptr_q     <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         wel_q     <= 1'b0;
         is_wr_q   <= 1'b0;
         dummy_q   <= 1'b0;
         io_o_q    <= '0;
         io_oe_q   <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (cs_s2_q) begin
            state_q <= S_IDLE;
            io_o_q  <= '0;
            io_oe_q <= '0;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            if (is_wr_q) begin
               wel_q <= 1'b0;
            end
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q <= S_CMD;
                  cnt_q   <= '0;
               end
               S_CMD: begin
                  if (sclk_rise) begin
                     sh_q  <= cmd_d;
                     cnt_q <= cnt_q + 8'd1;
                     if (cnt_q == 8'd7) begin
                        cnt_q   <= '0;
                        lane_q  <= L_X1;
                        dummy_q <= 1'b0;
                        state_q <= S_ADDR;
                        case (cmd_d)
                           8'h03: ;
                           8'h3B: begin lane_q <= L_X2; dummy_q <= 1'b1; end
                           8'h6B: begin lane_q <= L_X4; dummy_q <= 1'b1; end
                           8'h02: is_wr_q <= 1'b1;
                           8'h32: begin lane_q <= L_X4; is_wr_q <= 1'b1; end
                           8'h05: state_q <= S_STAT;
                           8'h06: begin wel_q <= 1'b1; state_q <= S_IGNORE; end
                           8'h04: begin wel_q <= 1'b0; state_q <= S_IGNORE; end
                           default: state_q <= S_IGNORE;
                        endcase
                     end
                  end
               end
               S_ADDR: begin
                  if (sclk_rise) begin
                     // Only the low AW address bits survive the shift; upper bits fall off the top.
                     ptr_q <= {ptr_q[AW-2:0], io_s2_q[0]};
                     cnt_q <= cnt_q + 8'd1;
                     if (cnt_q == 8'd23) begin
                        cnt_q <= '0;
                        if (is_wr_q) begin
                           state_q <= wel_q ? S_WDATA : S_IGNORE;
                        end else if (dummy_q && (DUMMY_N > 0)) begin
                           state_q <= S_DUMMY;
                        end else begin
                           state_q <= S_RDATA;
                        end
                     end
                  end
               end
               S_DUMMY: begin
                  if (sclk_rise) begin
                     if (cnt_q == 8'(DUMMY_N - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_RDATA;
                     end else begin
                        cnt_q <= cnt_q + 8'd1;
                     end
                  end
               end
               S_RDATA, S_STAT: begin
                  if (sclk_fall) begin
                     io_o_q  <= io_d;
                     io_oe_q <= oe_d;
                     tx_q    <= tx_d;
                     if (cnt_q == last_beat) begin
                        cnt_q <= '0;
                        if (state_q == S_RDATA) begin
                           ptr_q <= ptr_q + 1'b1;
                        end
                     end else begin
                        cnt_q <= cnt_q + 8'd1;
                     end
                  end
               end
               S_WDATA: begin
                  if (sclk_rise) begin
                     sh_q <= wsh_d;
                     if (cnt_q == last_beat) begin
                        cnt_q     <= '0;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= ptr_q;
                        wr_data_q <= wsh_d;
                        ptr_q     <= ptr_q + 1'b1;
                     end else begin
                        cnt_q <= cnt_q + 8'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // The QSPI write is applied last so it wins a same-address collision with the backdoor.
   always_ff @(posedge clk_i) begin
      if (bd_we_i) begin
         mem[bd_addr_i] <= bd_wdata_i;
      end
      if (wr_en_q) begin
         mem[wr_addr_q] <= wr_data_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bd_rdata_q <= '0;
      end else begin
         bd_rdata_q <= mem[bd_addr_i];
      end
   end

   assign qspi.io_o    = io_o_q;
   assign qspi.io_oe_o = io_oe_q;
   assign bd_rdata_o   = bd_rdata_q;
endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb/tb_qspi_flash_responder.sv - scoreboard bench for the QSPI flash responder
module tb_qspi_flash_responder;
   localparam int DEPTH   = 256;
   localparam int DUMMY_N = 8;
   localparam int AW      = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] bd_addr;
   logic [7:0]    bd_wdata;
   logic          bd_we;
   logic [7:0]    bd_rdata;

   qspi_flash_responder_if tif ();

   qspi_flash_responder #(.DEPTH(DEPTH), .DUMMY_N(DUMMY_N)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .qspi       (tif),
      .bd_addr_i  (bd_addr),
      .bd_wdata_i (bd_wdata),
      .bd_we_i    (bd_we),
      .bd_rdata_o (bd_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] ref_mem [DEPTH];
   logic       ref_wel = 1'b0;
   logic [7:0] wr_buf [16];

   logic [7:0] exp_rd_q [$];
   logic [7:0] exp_bd_q [$];

   logic       mon_rd_en  = 1'b0;
   logic       mon_oe_chk = 1'b0;
   logic [1:0] mon_lane   = 2'd0;
   logic [3:0] mon_exp_oe = 4'd0;
   int         mon_beat   = 0;
   logic [7:0] mon_acc    = 8'd0;
   logic       bd_req     = 1'b0;
   logic       bd_req_d   = 1'b0;

   function automatic void check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic int beats_of(logic [1:0] l);
      return (l == 2'd2) ? 2 : (l == 2'd1) ? 4 : 8;
   endfunction

   // QSPI monitor: master-side sampling on each SCLK rise
   initial forever begin
      @(posedge tif.sclk_i);
      if (mon_oe_chk) check("io_oe", tif.io_oe_o, mon_exp_oe);
      if (mon_rd_en) begin
         case (mon_lane)
            2'd0:    mon_acc = {mon_acc[6:0], tif.io_o[1]};
            2'd1:    mon_acc = {mon_acc[5:0], tif.io_o[1:0]};
            default: mon_acc = {mon_acc[3:0], tif.io_o};
         endcase
         mon_beat++;
         if (mon_beat == beats_of(mon_lane)) begin
            mon_beat = 0;
            if (exp_rd_q.size() == 0) check("rd_underflow", 1, 0);
            else check("rd_byte", mon_acc, exp_rd_q.pop_front());
         end
      end else begin
         mon_beat = 0;
      end
   end

   always @(posedge clk) bd_req_d <= bd_req;

   initial forever begin
      @(negedge clk);
      if (bd_req_d) begin
         if (exp_bd_q.size() == 0) check("bd_underflow", 1, 0);
         else check("bd_rdata", bd_rdata, exp_bd_q.pop_front());
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_addr = a; bd_wdata = d; bd_we = 1'b1;
      ref_mem[a] = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic bd_read(input logic [AW-1:0] a);
      @(negedge clk);
      bd_addr = a; bd_req = 1'b1;
      exp_bd_q.push_back(ref_mem[a]);
      @(negedge clk);
      bd_req = 1'b0;
   endtask

   task automatic clk_bit(input logic [3:0] v);
      tif.io_i = v;
      repeat (4) @(negedge clk);
      tif.sclk_i = 1'b1;
      repeat (4) @(negedge clk);
      tif.sclk_i = 1'b0;
   endtask

   task automatic frame_start();
      @(negedge clk);
      tif.cs_ni  = 1'b0;
      mon_exp_oe = 4'd0;
      mon_oe_chk = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic frame_end();
      repeat (4) @(negedge clk);
      tif.cs_ni  = 1'b1;
      mon_oe_chk = 1'b0;
      mon_rd_en  = 1'b0;
      repeat (8) @(negedge clk);
      check("idle_oe", tif.io_oe_o, 0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) clk_bit({3'b000, b[i]});
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 23; i >= 0; i--) clk_bit({3'b000, a[i]});
   endtask

   task automatic read_data(input logic [1:0] lane, input int n, input logic [3:0] oe);
      mon_lane   = lane;
      mon_exp_oe = oe;
      mon_rd_en  = 1'b1;
      repeat (n * beats_of(lane)) clk_bit(4'($urandom));
      mon_rd_en  = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] op, input logic [23:0] a, input int n);
      logic [1:0]    lane;
      logic [3:0]    oe;
      logic [AW-1:0] idx;
      lane = (op == 8'h6B) ? 2'd2 : (op == 8'h3B) ? 2'd1 : 2'd0;
      oe   = (op == 8'h6B) ? 4'b1111 : (op == 8'h3B) ? 4'b0011 : 4'b0010;
      for (int i = 0; i < n; i++) begin
         idx = a[AW-1:0] + AW'(i);
         exp_rd_q.push_back(ref_mem[idx]);
      end
      frame_start();
      send_byte(op);
      send_addr(a);
      if (op != 8'h03) repeat (DUMMY_N) clk_bit(4'($urandom));
      read_data(lane, n, oe);
      frame_end();
   endtask

   task automatic do_write(input logic [7:0] op, input logic [23:0] a, input int n, input int extra_nib);
      logic [AW-1:0] idx;
      frame_start();
      send_byte(op);
      send_addr(a);
      for (int i = 0; i < n; i++) begin
         if (op == 8'h32) begin
            clk_bit(wr_buf[i][7:4]);
            clk_bit(wr_buf[i][3:0]);
         end else begin
            send_byte(wr_buf[i]);
         end
      end
      if (extra_nib > 0) clk_bit(wr_buf[n][7:4]);
      frame_end();
      if (ref_wel) begin
         for (int i = 0; i < n; i++) begin
            idx = a[AW-1:0] + AW'(i);
            ref_mem[idx] = wr_buf[i];
         end
      end
      ref_wel = 1'b0;
   endtask

   task automatic do_simple(input logic [7:0] op);
      frame_start();
      send_byte(op);
      frame_end();
      if (op == 8'h06) ref_wel = 1'b1;
      if (op == 8'h04) ref_wel = 1'b0;
   endtask

   task automatic do_rdsr(input int n);
      for (int i = 0; i < n; i++) exp_rd_q.push_back({6'b0, ref_wel, 1'b0});
      frame_start();
      send_byte(8'h05);
      read_data(2'd0, n, 4'b0010);
      frame_end();
   endtask

   initial begin
      logic [23:0] a;
      int          n;
      tif.sclk_i = 1'b0; tif.cs_ni = 1'b1; tif.io_i = 4'd0;
      bd_addr = '0; bd_wdata = '0; bd_we = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_io_oe", tif.io_oe_o, 0);
      check("rst_io_o", tif.io_o, 0);
      check("rst_bd_rdata", bd_rdata, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < DEPTH; i++) bd_write(AW'(i), 8'($urandom));
      bd_write(8'h10, 8'hA5); bd_write(8'h11, 8'h3C);
      bd_write(8'h12, 8'h0F); bd_write(8'h13, 8'hF0);
      bd_read(8'h10); bd_read(8'h13);

      do_read(8'h03, 24'h000010, 4);
      do_read(8'h6B, 24'h0000FE, 3);
      do_read(8'h3B, 24'hABCDE7, 3);

      wr_buf[0] = 8'h55;
      do_write(8'h02, 24'h000030, 1, 0);
      bd_read(8'h30);

      do_simple(8'h06);
      do_rdsr(2);
      wr_buf[0] = 8'h11; wr_buf[1] = 8'h22;
      do_write(8'h02, 24'h000020, 2, 0);
      bd_read(8'h20); bd_read(8'h21);
      do_rdsr(1);

      do_simple(8'h06);
      for (int i = 0; i < 4; i++) wr_buf[i] = 8'($urandom);
      do_write(8'h32, 24'h000040, 3, 1);
      for (int i = 0; i < 4; i++) bd_read(AW'(8'h40 + i));
      do_rdsr(1);

      // reset in the middle of a READ data phase
      do_simple(8'h06);
      exp_rd_q.push_back(ref_mem[8'h50]);
      frame_start();
      send_byte(8'h03);
      send_addr(24'h000050);
      read_data(2'd0, 1, 4'b0010);
      repeat (3) clk_bit(4'd0);
      rst = 1'b1;
      #1;
      check("rst_mid_oe", tif.io_oe_o, 0);
      mon_oe_chk = 1'b0;
      tif.cs_ni  = 1'b1;
      ref_wel    = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      do_read(8'h03, 24'h000051, 2);
      do_rdsr(1);

      frame_start();
      send_byte(8'hAB);
      repeat (32) clk_bit(4'($urandom));
      frame_end();
      do_read(8'h03, 24'h0000A0, 2);

      do_simple(8'h06);
      do_simple(8'h04);
      do_rdsr(1);

      for (int it = 0; it < 20; it++) begin
         a = 24'($urandom);
         n = $urandom_range(1, 4);
         for (int i = 0; i < 5; i++) wr_buf[i] = 8'($urandom);
         case ($urandom_range(0, 7))
            0: do_read(8'h03, a, n);
            1: do_read(8'h3B, a, n);
            2: do_read(8'h6B, a, n);
            3: do_write(8'h02, a, n, 0);
            4: do_write(8'h32, a, n, 0);
            5: do_simple(8'h06);
            6: do_rdsr($urandom_range(1, 2));
            default: do_simple(8'h04);
         endcase
      end

      for (int i = 0; i < 12; i++) bd_read(AW'($urandom));
      repeat (4) @(negedge clk);
      check("rd_q_empty", exp_rd_q.size(), 0);
      check("bd_q_empty", exp_bd_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
